usb_rx_packet_assembler: RTL and testbench

- Upstream stage of the endpoint transaction target: converts the byte stream from the SIE/PHY receive path into packets.
- Outputs whole packets: a 24-bit token word, an 88-bit data packet word, and a one-cycle first-packet strobe that starts the transaction FSM.
- Classifies each packet by PID, checks the PID complement nibble, packet length and framing, and drops malformed or aborted packets.

---
 rtl/usb_rx_packet_assembler_if.sv | 35 +++
 rtl/usb_rx_packet_assembler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_usb_rx_packet_assembler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_packet_assembler_if.sv
// Byte-stream receive side and packet-level result side of the USB RX packet assembler.
// master drives the received bytes and observes results; slave is the assembler itself.
interface usb_rx_packet_assembler_if #(
    parameter int MAX_PAYLOAD = 8
);
    localparam int LW = $clog2(MAX_PAYLOAD + 1);

    logic [7:0]                     rx_byte;
    logic                           rx_valid;
    logic                           rx_sop;
    logic                           rx_eop;
    logic                           rx_err;

    logic [23:0]                    token;
    logic                           token_valid;
    logic [8*(MAX_PAYLOAD+3)-1:0]   data_pkt;
    logic [LW-1:0]                  data_len;
    logic                           data_valid;
    logic                           first_packet;
    logic                           pid_err;
    logic                           len_err;
    logic                           crc5_err;

    modport master (
        output rx_byte, rx_valid, rx_sop, rx_eop, rx_err,
        input  token, token_valid, data_pkt, data_len, data_valid,
        input  first_packet, pid_err, len_err, crc5_err
    );

    modport slave (
        input  rx_byte, rx_valid, rx_sop, rx_eop, rx_err,
        output token, token_valid, data_pkt, data_len, data_valid,
        output first_packet, pid_err, len_err, crc5_err
    );
endinterface

// File: rtl/usb_rx_packet_assembler.sv
// Assembles SIE/PHY receive bytes into token and data packets, dropping malformed ones.
// Define USB_CRC5_CHECK_EN to CRC5-check OUT/IN/SOF/SETUP tokens before they are released.
module usb_rx_packet_assembler #(
    parameter int MAX_PAYLOAD = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    usb_rx_packet_assembler_if.slave   bus
);
    localparam int PW = 8 * MAX_PAYLOAD;
    localparam int DW = 8 * (MAX_PAYLOAD + 3);
    localparam int CW = $clog2(MAX_PAYLOAD + 4);
    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_N = CW'(MAX_PAYLOAD + 2);

    typedef enum logic [1:0] {IDLE, TOK, DAT, DROP} state_t;
    typedef enum logic [1:0] {CLS_TOK, CLS_DAT, CLS_HS, CLS_BAD} pid_class_t;

    state_t          state_q;
    logic [7:0]      pid_q;
    logic [7:0]      byte1_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [PW-1:0]   payload_q;
    logic [15:0]     hold_q;

    logic [23:0]     token_q;
    logic [DW-1:0]   dataPkt_q;
    logic [LW-1:0]   dataLen_q;
    logic            tokenValid_q;
    logic            dataValid_q;
    logic            firstPacket_q;
    logic            pidErr_q;
    logic            lenErr_q;

    logic            pidGood;
    pid_class_t      pidClass;
    logic [PW-1:0]   payloadNext;
    logic [23:0]     tokWord;

    assign pidGood = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]);
    assign tokWord = {pid_q, byte1_q, bus.rx_byte};

    always_comb begin
        pidClass = CLS_BAD;
        case (bus.rx_byte[7:4])
            4'b0001, 4'b1001, 4'b0101, 4'b1101: pidClass = CLS_TOK;
            4'b0011, 4'b1011:                   pidClass = CLS_DAT;
            4'b0010, 4'b1010, 4'b1110:          pidClass = CLS_HS;
            default:                            pidClass = CLS_BAD;
        endcase
    end

    // The two most recent bytes stay in hold_q until it is known whether they are CRC or payload.
    always_comb begin
        payloadNext = payload_q;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (cnt_q >= CW'(2) && (cnt_q - CW'(2)) == CW'(i)) begin
                payloadNext[PW-8-8*i +: 8] = hold_q[15:8];
            end
        end
    end

`ifdef USB_CRC5_CHECK_EN
    logic crc5Err_q;
    logic crcOk;

    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 10; i >= 0; i--) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    assign crcOk = (tokWord[4:0] == ~crc5(tokWord[15:5]));
    assign bus.crc5_err = crc5Err_q;
`else
    assign bus.crc5_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pid_q         <= '0;
            byte1_q       <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            payload_q     <= '0;
            hold_q        <= '0;
            token_q       <= '0;
            dataPkt_q     <= '0;
            dataLen_q     <= '0;
            tokenValid_q  <= 1'b0;
            dataValid_q   <= 1'b0;
            firstPacket_q <= 1'b0;
            pidErr_q      <= 1'b0;
            lenErr_q      <= 1'b0;
`ifdef USB_CRC5_CHECK_EN
            crc5Err_q     <= 1'b0;
`endif
        end else begin
            tokenValid_q  <= 1'b0;
            dataValid_q   <= 1'b0;
            firstPacket_q <= 1'b0;
            pidErr_q      <= 1'b0;
            lenErr_q      <= 1'b0;
`ifdef USB_CRC5_CHECK_EN
            crc5Err_q     <= 1'b0;
`endif
            if (bus.rx_err) begin
                state_q <= (bus.rx_valid && bus.rx_eop) ? IDLE : DROP;
                cnt_q   <= '0;
                tmo_q   <= '0;
            end else if (bus.rx_valid && bus.rx_sop) begin
                // A start byte always begins a new packet, truncating any one in progress.
                cnt_q <= '0;
                tmo_q <= '0;
                pid_q <= bus.rx_byte;
                if (state_q == TOK || state_q == DAT) begin
                    lenErr_q <= 1'b1;
                end
                if (!pidGood) begin
                    pidErr_q <= 1'b1;
                    state_q  <= bus.rx_eop ? IDLE : DROP;
                end else begin
                    case (pidClass)
                        CLS_TOK: begin
                            if (bus.rx_eop) begin
                                lenErr_q <= 1'b1;
                                state_q  <= IDLE;
                            end else begin
                                state_q  <= TOK;
                            end
                        end
                        CLS_DAT: begin
                            if (bus.rx_eop) begin
                                lenErr_q  <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                payload_q <= '0;
                                hold_q    <= '0;
                                state_q   <= DAT;
                            end
                        end
                        CLS_HS: begin
                            if (bus.rx_eop) begin
                                token_q       <= {bus.rx_byte, 16'h0000};
                                tokenValid_q  <= 1'b1;
                                firstPacket_q <= 1'b1;
                                state_q       <= IDLE;
                            end else begin
                                lenErr_q      <= 1'b1;
                                state_q       <= DROP;
                            end
                        end
                        default: begin
                            pidErr_q <= 1'b1;
                            state_q  <= bus.rx_eop ? IDLE : DROP;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    DROP: begin
                        if (bus.rx_valid && bus.rx_eop) begin
                            state_q <= IDLE;
                        end
                    end
                    TOK: begin
                        if (bus.rx_valid) begin
                            tmo_q <= '0;
                            if (cnt_q == '0) begin
                                if (bus.rx_eop) begin
                                    lenErr_q <= 1'b1;
                                    state_q  <= IDLE;
                                end else begin
                                    byte1_q  <= bus.rx_byte;
                                    cnt_q    <= CW'(1);
                                end
                            end else if (!bus.rx_eop) begin
                                lenErr_q <= 1'b1;
                                state_q  <= DROP;
                            end else begin
                                state_q  <= IDLE;
`ifdef USB_CRC5_CHECK_EN
                                if (crcOk) begin
                                    token_q       <= tokWord;
                                    tokenValid_q  <= 1'b1;
                                    firstPacket_q <= 1'b1;
                                end else begin
                                    crc5Err_q     <= 1'b1;
                                end
`else
                                token_q       <= tokWord;
                                tokenValid_q  <= 1'b1;
                                firstPacket_q <= 1'b1;
`endif
                            end
                        end else if (TIMEOUT != 0) begin
                            if (tmo_q == TW'(TIMEOUT - 1)) begin
                                lenErr_q <= 1'b1;
                                tmo_q    <= '0;
                                state_q  <= IDLE;
                            end else begin
                                tmo_q    <= tmo_q + TW'(1);
                            end
                        end
                    end
                    DAT: begin
                        if (bus.rx_valid) begin
                            tmo_q     <= '0;
                            payload_q <= payloadNext;
                            hold_q    <= {hold_q[7:0], bus.rx_byte};
                            cnt_q     <= cnt_q + CW'(1);
                            // cnt_q counts bytes already stored, so this byte is number cnt_q+1.
                            if (bus.rx_eop) begin
                                state_q <= IDLE;
                                if (cnt_q != '0 && cnt_q < MAX_N) begin
                                    dataPkt_q     <= {pid_q, payloadNext, hold_q[7:0], bus.rx_byte};
                                    dataLen_q     <= LW'(cnt_q - CW'(1));
                                    dataValid_q   <= 1'b1;
                                    firstPacket_q <= 1'b1;
                                end else begin
                                    lenErr_q      <= 1'b1;
                                end
                            end else if (cnt_q == MAX_N) begin
                                lenErr_q <= 1'b1;
                                state_q  <= DROP;
                            end
                        end else if (TIMEOUT != 0) begin
                            if (tmo_q == TW'(TIMEOUT - 1)) begin
                                lenErr_q <= 1'b1;
                                tmo_q    <= '0;
                                state_q  <= IDLE;
                            end else begin
                                tmo_q    <= tmo_q + TW'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.token        = token_q;
    assign bus.token_valid  = tokenValid_q;
    assign bus.data_pkt     = dataPkt_q;
    assign bus.data_len     = dataLen_q;
    assign bus.data_valid   = dataValid_q;
    assign bus.first_packet = firstPacket_q;
    assign bus.pid_err      = pidErr_q;
    assign bus.len_err      = lenErr_q;
endmodule

// File: tb/tb_usb_rx_packet_assembler.sv
// Directed, table-driven bench for usb_rx_packet_assembler plus timeout and reset sequences.
// Honours USB_CRC5_CHECK_EN for the one vector whose token CRC5 is wrong.
module tb_usb_rx_packet_assembler;
    localparam int MAX_PAYLOAD = 8;
    localparam int TIMEOUT     = 16;

    // Pulse vector order: {token_valid, data_valid, first_packet, pid_err, len_err, crc5_err}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] TV   = 6'b101000;
    localparam logic [5:0] DV   = 6'b011000;
    localparam logic [5:0] PE   = 6'b000100;
    localparam logic [5:0] LE   = 6'b000010;
    localparam logic [5:0] CE   = 6'b000001;

    typedef struct {
        string       name;
        logic        valid;
        logic        sop;
        logic        eop;
        logic        err;
        logic [7:0]  b;
        logic [5:0]  pulses;
        logic [23:0] tok;
        logic [87:0] pkt;
        logic [3:0]  len;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_rx_packet_assembler_if #(.MAX_PAYLOAD(MAX_PAYLOAD)) bus();

    usb_rx_packet_assembler #(
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t        vecs[$];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] expTok = '0;
    logic [87:0] expPkt = '0;
    logic [3:0]  expLen = '0;

    function automatic void addV(string name, logic valid, logic sop, logic eop, logic err,
                                 logic [7:0] b, logic [5:0] p,
                                 logic [23:0] tok, logic [87:0] pkt, logic [3:0] len);
        vec_t v;
        v.name = name; v.valid = valid; v.sop = sop; v.eop = eop; v.err = err;
        v.b = b; v.pulses = p; v.tok = tok; v.pkt = pkt; v.len = len;
        vecs.push_back(v);
    endfunction

    function automatic void bv(string name, logic [7:0] b, logic sop, logic eop, logic [5:0] p);
        addV(name, 1'b1, sop, eop, 1'b0, b, p, '0, '0, '0);
    endfunction

    task automatic applyStimulus(input logic valid, input logic sop, input logic eop,
                                 input logic err, input logic [7:0] b);
        bus.rx_valid = valid;
        bus.rx_sop   = sop;
        bus.rx_eop   = eop;
        bus.rx_err   = err;
        bus.rx_byte  = b;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expP);
        logic [5:0] got;
        got = {bus.token_valid, bus.data_valid, bus.first_packet, bus.pid_err, bus.len_err, bus.crc5_err};
        total++;
        if (got !== expP) begin
            bad++;
            $display("[TB] FAIL %s pulses got=%b want=%b", name, got, expP);
        end
        total++;
        if (bus.token !== expTok) begin
            bad++;
            $display("[TB] FAIL %s token got=%h want=%h", name, bus.token, expTok);
        end
        total++;
        if (bus.data_pkt !== expPkt || bus.data_len !== expLen) begin
            bad++;
            $display("[TB] FAIL %s data got=%h/%0d want=%h/%0d", name, bus.data_pkt, bus.data_len, expPkt, expLen);
        end
    endtask

    task automatic step(input string name, input logic valid, input logic sop, input logic eop,
                        input logic err, input logic [7:0] b, input logic [5:0] expP);
        @(negedge clk);
        applyStimulus(valid, sop, eop, err, b);
        @(posedge clk);
        #1;
        checkOutput(name, expP);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #12;
        checkOutput("reset", NONE);
        @(negedge clk);
        rst = 1'b1;

        bv("setup_b0", 8'hD2, 1, 0, NONE);
        bv("setup_b1", 8'h00, 0, 0, NONE);
        addV("setup_b2", 1, 0, 1, 0, 8'h08, TV, 24'hD20008, '0, '0);
        bv("crc_b0", 8'hD2, 1, 0, NONE);
        bv("crc_b1", 8'h00, 0, 0, NONE);
`ifdef USB_CRC5_CHECK_EN
        addV("crc_b2", 1, 0, 1, 0, 8'h09, CE, '0, '0, '0);
`else
        addV("crc_b2", 1, 0, 1, 0, 8'h09, TV, 24'hD20009, '0, '0);
`endif
        bv("d3_pid", 8'h3C, 1, 0, NONE);
        bv("d3_11", 8'h11, 0, 0, NONE);
        bv("d3_22", 8'h22, 0, 0, NONE);
        bv("d3_33", 8'h33, 0, 0, NONE);
        bv("d3_aa", 8'hAA, 0, 0, NONE);
        addV("d3_bb", 1, 0, 1, 0, 8'hBB, DV, '0, 88'h3C_1122330000000000_AABB, 4'd3);
        addV("idle", 0, 0, 0, 0, 8'h00, NONE, '0, '0, '0);
        bv("badpid", 8'h4C, 1, 0, PE);
        bv("badpid_drop", 8'h12, 0, 0, NONE);
        bv("badpid_eop", 8'h34, 0, 1, NONE);
        addV("ack", 1, 1, 1, 0, 8'h2D, TV, 24'h2D0000, '0, '0);
        bv("d0_pid", 8'hB4, 1, 0, NONE);
        bv("d0_12", 8'h12, 0, 0, NONE);
        addV("d0_34", 1, 0, 1, 0, 8'h34, DV, '0, 88'hB4_0000000000000000_1234, 4'd0);
        bv("over_pid", 8'h3C, 1, 0, NONE);
        for (int i = 1; i <= 10; i++) bv("over_byte", 8'(i), 0, 0, NONE);
        bv("over_11th", 8'h0B, 0, 0, LE);
        bv("over_eop", 8'h0C, 0, 1, NONE);
        bv("err_pid", 8'h1E, 1, 0, NONE);
        addV("err_byte", 1, 0, 0, 1, 8'h55, NONE, '0, '0, '0);
        bv("err_eop", 8'h66, 0, 1, NONE);
        bv("short_pid", 8'h3C, 1, 0, NONE);
        bv("short_eop", 8'h77, 0, 1, LE);
        bv("max_pid", 8'hB4, 1, 0, NONE);
        for (int i = 1; i <= 8; i++) bv("max_byte", 8'(i), 0, 0, NONE);
        bv("max_cc", 8'hCC, 0, 0, NONE);
        addV("max_dd", 1, 0, 1, 0, 8'hDD, DV, '0, 88'hB4_0102030405060708_CCDD, 4'd8);
        bv("in_pid", 8'h96, 1, 0, NONE);
        bv("in_short", 8'h12, 0, 1, LE);
        bv("sof_pid", 8'h5A, 1, 0, NONE);
        bv("sof_b1", 8'h01, 0, 0, NONE);
        bv("sof_long", 8'h02, 0, 0, LE);
        bv("sof_drop", 8'h03, 0, 1, NONE);
        bv("restart_pid", 8'h3C, 1, 0, NONE);
        bv("restart_b", 8'h11, 0, 0, NONE);
        addV("restart_nak", 1, 1, 1, 0, 8'hA5, TV | LE, 24'hA50000, '0, '0);
        bv("stall_long", 8'hE1, 1, 0, LE);
        bv("stall_drop", 8'h00, 0, 1, NONE);
        bv("out_1byte", 8'h1E, 1, 1, LE);
        bv("reserved", 8'h0F, 1, 1, PE);
        addV("stall", 1, 1, 1, 0, 8'hE1, TV, 24'hE10000, '0, '0);
        bv("erreop_pid", 8'hD2, 1, 0, NONE);
        addV("erreop", 1, 0, 1, 1, 8'h00, NONE, '0, '0, '0);
        bv("again_b0", 8'hD2, 1, 0, NONE);
        bv("again_b1", 8'h00, 0, 0, NONE);
        addV("again_b2", 1, 0, 1, 0, 8'h08, TV, 24'hD20008, '0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pulses[5]) expTok = vecs[i].tok;
            if (vecs[i].pulses[4]) begin
                expPkt = vecs[i].pkt;
                expLen = vecs[i].len;
            end
            step(vecs[i].name, vecs[i].valid, vecs[i].sop, vecs[i].eop, vecs[i].err,
                 vecs[i].b, vecs[i].pulses);
        end

        // Timeout fires on exactly the TIMEOUT-th idle cycle inside a token.
        step("tmo_pid", 1, 1, 0, 0, 8'hD2, NONE);
        for (int k = 1; k <= 20; k++) begin
            step("tmo_idle", 0, 0, 0, 0, 8'h00, (k == TIMEOUT) ? LE : NONE);
        end

        // Gaps of TIMEOUT-1 idle cycles between bytes must not abort.
        step("gap_pid", 1, 1, 0, 0, 8'h3C, NONE);
        for (int k = 0; k < TIMEOUT - 1; k++) step("gap_idle1", 0, 0, 0, 0, 8'h00, NONE);
        step("gap_aa", 1, 0, 0, 0, 8'hAA, NONE);
        for (int k = 0; k < TIMEOUT - 1; k++) step("gap_idle2", 0, 0, 0, 0, 8'h00, NONE);
        expPkt = 88'h3C_0000000000000000_AABB;
        expLen = 4'd0;
        step("gap_bb", 1, 0, 1, 0, 8'hBB, DV);

        // Asynchronous reset mid-packet clears outputs without waiting for a clock edge.
        step("rstmid_pid", 1, 1, 0, 0, 8'h3C, NONE);
        step("rstmid_b", 1, 0, 0, 0, 8'h11, NONE);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        expTok = '0;
        expPkt = '0;
        expLen = '0;
        checkOutput("rst_async", NONE);
        @(negedge clk);
        rst = 1'b1;
        expTok = 24'h2D0000;
        step("post_ack", 1, 1, 1, 0, 8'h2D, TV);
        step("post_pid", 1, 1, 0, 0, 8'h3C, NONE);
        step("post_11", 1, 0, 0, 0, 8'h11, NONE);
        step("post_22", 1, 0, 0, 0, 8'h22, NONE);
        step("post_33", 1, 0, 0, 0, 8'h33, NONE);
        step("post_aa", 1, 0, 0, 0, 8'hAA, NONE);
        expPkt = 88'h3C_1122330000000000_AABB;
        expLen = 4'd3;
        step("post_bb", 1, 0, 1, 0, 8'hBB, DV);
        step("post_idle", 0, 0, 0, 0, 8'h00, NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
